// File: rtl/cpu_acc_sequencer_if.sv
// Instruction handshake and ALU connection bundle for the accumulator sequencer.
// The master side is the instruction source and the external combinational ALU.
interface cpu_acc_sequencer_if;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_opcode;
   logic [7:0]  alu_result;
   logic [7:0]  acc;
   logic        zero;
   logic        done;

   modport master (
      output instr, instr_valid, alu_result,
      input  instr_ready, alu_a, alu_b, alu_opcode, acc, zero, done
   );

   modport slave (
      input  instr, instr_valid, alu_result,
      output instr_ready, alu_a, alu_b, alu_opcode, acc, zero, done
   );
endinterface

// File: rtl/cpu_acc_sequencer.sv
// Four-state accumulator sequencer feeding an external ALU: one instruction per 4 cycles,
// done in the third cycle after the handshake; new instructions are only accepted in IDLE.
module cpu_acc_sequencer #(
   parameter int         NUM_REGS  = 4,
   parameter logic [7:0] ACC_RESET = 8'h00
) (
   input logic                clk,
   input logic                reset,
   cpu_acc_sequencer_if.slave sq
);
   localparam int IDXW = (NUM_REGS > 2) ? 2 : 1;

   typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

   state_t          state_q, state_d;
   logic [15:0]     instr_q, instr_d;
   logic [7:0]      operand_q, operand_d;
   logic [7:0]      result_q, result_d;
   logic [7:0]      acc_q, acc_d;
   logic            zero_q, zero_d;
   logic [7:0]      regs_q [NUM_REGS];
   logic [7:0]      regs_d [NUM_REGS];
   logic [IDXW-1:0] idx;
   logic            instr_unused;

   // Upper index bits are dropped for small register files; bit 10 is reserved.
   assign idx          = instr_q[8 +: IDXW];
   assign instr_unused = ^instr_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         instr_q   <= '0;
         operand_q <= '0;
         result_q  <= '0;
         acc_q     <= ACC_RESET;
         zero_q    <= (ACC_RESET == 8'h00);
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         instr_q   <= instr_d;
         operand_q <= operand_d;
         result_q  <= result_d;
         acc_q     <= acc_d;
         zero_q    <= zero_d;
         regs_q    <= regs_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      instr_d   = instr_q;
      operand_d = operand_q;
      result_d  = result_q;
      acc_d     = acc_q;
      zero_d    = zero_q;
      regs_d    = regs_q;
      unique case (state_q)
         IDLE: begin
            if (sq.instr_valid) begin
               instr_d = sq.instr;
               state_d = DECODE;
            end
         end
         DECODE: begin
            operand_d = instr_q[11] ? instr_q[7:0] : regs_q[idx];
            state_d   = EXEC;
         end
         EXEC: begin
            result_d = sq.alu_result;
            state_d  = WB;
         end
         WB: begin
            // Writeback lands before the next DECODE, so a following read sees the store.
            if (instr_q[15]) begin
               regs_d[idx] = acc_q;
            end else begin
               acc_d  = result_q;
               zero_d = (result_q == 8'h00);
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign sq.instr_ready = (state_q == IDLE);
   assign sq.alu_a       = acc_q;
   assign sq.alu_b       = operand_q;
   assign sq.alu_opcode  = instr_q[14:12];
   assign sq.acc         = acc_q;
   assign sq.zero        = zero_q;
   assign sq.done        = (state_q == WB);
endmodule

// File: tb/tb_cpu_acc_sequencer.sv
// Directed bench for cpu_acc_sequencer with a behavioural model of the external ALU.
// ALU opcodes: 000 AND, 001 OR, 010 XOR, 011 pass b, 100 ADD, 101 SUB, 110 SHL acc, 111 SHR acc.
module tb_cpu_acc_sequencer;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   cpu_acc_sequencer_if bus();

   cpu_acc_sequencer #(
      .NUM_REGS  (4),
      .ACC_RESET (8'h00)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sq    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [2:0] op);
      case (op)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a ^ b;
         3'b011:  return b;
         3'b100:  return a + b;
         3'b101:  return a - b;
         3'b110:  return {a[6:0], 1'b0};
         default: return {1'b0, a[7:1]};
      endcase
   endfunction

   always_comb bus.alu_result = alu_fn(bus.alu_a, bus.alu_b, bus.alu_opcode);

   // Handshake one instruction, then watch four cycles: latency to done, busy cycles, done pulses.
   task automatic issue(input logic [15:0] w, output int lat, output int rdy_low,
                        output int done_cnt);
      @(negedge clk);
      bus.instr       = w;
      bus.instr_valid = 1'b1;
      lat      = 0;
      rdy_low  = 0;
      done_cnt = 0;
      @(posedge clk);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (i == 1) bus.instr_valid = 1'b0;
         if (bus.done) begin
            done_cnt++;
            if (lat == 0) lat = i;
         end
         if (!bus.instr_ready) rdy_low++;
      end
   endtask

   task automatic test_reset();
      reset           = 1'b1;
      bus.instr       = 16'h0000;
      bus.instr_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.acc !== 8'h00) begin
         errors++; $display("FAIL reset_acc: got %h expected 00", bus.acc);
      end
      checks++;
      if (bus.zero !== 1'b1 || bus.done !== 1'b0 || bus.instr_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: zero=%b done=%b ready=%b expected 1 0 1",
                  bus.zero, bus.done, bus.instr_ready);
      end
      checks++;
      if (bus.alu_opcode !== 3'b000 || bus.alu_b !== 8'h00) begin
         errors++;
         $display("FAIL reset_alu_regs: opcode=%b b=%h expected 000 00", bus.alu_opcode, bus.alu_b);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: ready=%b done=%b expected 1 0", bus.instr_ready, bus.done);
      end
   endtask

   task automatic test_first_op();
      int lat, rl, dc;
      issue(16'h1805, lat, rl, dc);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL first_latency: got %0d expected 3", lat); end
      checks++;
      if (rl !== 3) begin errors++; $display("FAIL first_ready_low: got %0d expected 3", rl); end
      checks++;
      if (dc !== 1) begin errors++; $display("FAIL first_done_cnt: got %0d expected 1", dc); end
      checks++;
      if (bus.acc !== 8'h05 || bus.zero !== 1'b0) begin
         errors++; $display("FAIL first_acc: got %h/%b expected 05/0", bus.acc, bus.zero);
      end
   endtask

   task automatic test_wrap();
      int lat, rl, dc;
      issue(16'h5807, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'hFE || bus.zero !== 1'b0) begin
         errors++; $display("FAIL sub_wrap: got %h/%b expected FE/0", bus.acc, bus.zero);
      end
      issue(16'h4802, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'h00 || bus.zero !== 1'b1) begin
         errors++; $display("FAIL add_wrap_zero: got %h/%b expected 00/1", bus.acc, bus.zero);
      end
   endtask

   task automatic test_store_hazard();
      int lat, rl, dc;
      issue(16'h183C, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'h3C) begin errors++; $display("FAIL load_3c: got %h expected 3C", bus.acc); end
      issue(16'h8200, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'h3C || bus.zero !== 1'b0 || dc !== 1) begin
         errors++;
         $display("FAIL store_keeps_acc: got %h/%b done=%0d expected 3C/0 1", bus.acc, bus.zero, dc);
      end
      issue(16'h2200, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'h00 || bus.zero !== 1'b1) begin
         errors++; $display("FAIL xor_reg2: got %h/%b expected 00/1", bus.acc, bus.zero);
      end
      issue(16'h3200, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'h3C) begin errors++; $display("FAIL read_reg2: got %h expected 3C", bus.acc); end
      issue(16'h3100, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'h00 || bus.zero !== 1'b1) begin
         errors++; $display("FAIL read_reg1: got %h/%b expected 00/1", bus.acc, bus.zero);
      end
   endtask

   task automatic test_shift();
      int lat, rl, dc;
      issue(16'h3C81, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'h81) begin errors++; $display("FAIL load_81_rsvd: got %h expected 81", bus.acc); end
      issue(16'h68FF, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'h02 || bus.zero !== 1'b0) begin
         errors++; $display("FAIL shl: got %h/%b expected 02/0", bus.acc, bus.zero);
      end
      issue(16'h78FF, lat, rl, dc);
      checks++;
      if (bus.acc !== 8'h01) begin errors++; $display("FAIL shr: got %h expected 01", bus.acc); end
   endtask

   task automatic test_back_to_back();
      int lat, rl, dc;
      logic [15:0] seq [4];
      int acc_cyc [4];
      int accepts, dones, idx;
      logic hs;
      seq[0] = 16'h4801; seq[1] = 16'h4802; seq[2] = 16'h4804; seq[3] = 16'h4808;
      issue(16'h3800, lat, rl, dc);
      accepts = 0; dones = 0; idx = 0;
      bus.instr       = seq[0];
      bus.instr_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         if (bus.done) dones++;
         hs = bus.instr_ready && bus.instr_valid;
         if (hs) begin
            if (accepts < 4) acc_cyc[accepts] = k;
            accepts++;
         end
         @(posedge clk);
         #1;
         if (hs) begin
            idx++;
            if (idx < 4) bus.instr = seq[idx];
            else bus.instr_valid = 1'b0;
         end
         @(negedge clk);
      end
      checks++;
      if (accepts !== 4) begin errors++; $display("FAIL b2b_accepts: got %0d expected 4", accepts); end
      checks++;
      if (dones !== 4) begin errors++; $display("FAIL b2b_dones: got %0d expected 4", dones); end
      if (accepts == 4) begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_cyc[i+1] - acc_cyc[i] !== 4) begin
               errors++;
               $display("FAIL b2b_spacing%0d: got %0d expected 4", i, acc_cyc[i+1] - acc_cyc[i]);
            end
         end
      end
      checks++;
      if (bus.acc !== 8'h0F) begin errors++; $display("FAIL b2b_acc: got %h expected 0F", bus.acc); end
   endtask

   task automatic test_reset_mid();
      int dones;
      dones = 0;
      @(negedge clk);
      bus.instr       = 16'h18AA;
      bus.instr_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.instr_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.alu_b !== 8'hAA || bus.instr_ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_exec_state: b=%h ready=%b expected AA 0", bus.alu_b, bus.instr_ready);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (bus.acc !== 8'h00 || bus.zero !== 1'b1 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_vals: acc=%h zero=%b done=%b expected 00 1 0",
                  bus.acc, bus.zero, bus.done);
      end
      repeat (2) begin
         @(negedge clk);
         if (bus.done) dones++;
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.instr_ready !== 1'b1) begin
         errors++; $display("FAIL mid_ready_after: got %b expected 1", bus.instr_ready);
      end
      repeat (5) begin
         if (bus.done) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones !== 0) begin errors++; $display("FAIL mid_no_done: got %0d expected 0", dones); end
      checks++;
      if (bus.acc !== 8'h00) begin errors++; $display("FAIL mid_no_wb: got %h expected 00", bus.acc); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_first_op();
      test_wrap();
      test_store_hazard();
      test_shift();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/cpu_acc_sequencer.md
Name: cpu_acc_sequencer

Overview:
Multi-cycle accumulator sequencer that sits directly upstream of the 8-bit CPU ALU. It accepts 16-bit instructions over a valid/ready handshake and holds the accumulator and a small register file. Operands and the 3-bit opcode drive the ALU, and the ALU result is written back into the accumulator. The ALU itself is purely combinational and lives outside this block, connected via the alu_* ports.

Parameters:
NUM_REGS, 4, register-file depth; power of two, 2..4; index is instr[9:8], upper bits ignored when NUM_REGS<4
ACC_RESET, 8'h00, accumulator value after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
instr  input  16  instruction word, sampled on handshake
instr_valid  input  1  instr is valid
instr_ready  output  1  block can accept an instruction (high only in IDLE)
alu_a  output  8  ALU operand a (= acc)
alu_b  output  8  ALU operand b (= operand register)
alu_opcode  output  3  ALU opcode (= latched instr[14:12])
alu_result  input  8  combinational result from ALU
acc  output  8  current accumulator
zero  output  1  acc == 0, updated at writeback
done  output  1  one-cycle pulse when an instruction retires

Behaviour:
- Decided interface rules: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset values: acc=ACC_RESET, all regfile entries 0, zero=(ACC_RESET==0), done=0, state=IDLE, instr_ready=1, operand reg=0, latched opcode=0.
- Instruction fields:
  - [15] kind: 0 = ALU op, 1 = store.
  - [14:12] ALU opcode.
  - [11] imm: 1 selects operand instr[7:0], 0 selects reg[instr[9:8]].
  - [9:8] register index.
  - [7:0] immediate.
  - [10] reserved and ignored.
- FSM states: IDLE -> DECODE -> EXEC -> WB -> IDLE.
- IDLE:
  - instr_ready=1.
  - When instr_valid && instr_ready, latch instr and go to DECODE.
  - When instr_valid=0, stay in IDLE.
- DECODE: load operand reg with the immediate or the register-file entry; go to EXEC.
- EXEC: alu_a/alu_b/alu_opcode are stable; capture alu_result into the result register; go to WB.
- WB:
  - ALU op: acc <= result; zero <= (result==0).
  - Store: reg[idx] <= acc; acc and zero unchanged.
  - done=1 in this cycle only; go to IDLE.
- Latency:
  - Handshake in cycle N; done asserted in cycle N+3.
  - Updated acc visible in cycle N+4.
  - Next instruction can be accepted in cycle N+4, giving a throughput of 1 instruction per 4 cycles.
- alu_a/alu_b/alu_opcode are always driven from registers; their values are only meaningful in EXEC.
- Arithmetic is mod 256 with no carry or borrow kept. Shift ops use acc only; operand b is ignored by the ALU.
- Regfile hazard: a store in WB followed by a read of the same register in the next instruction's DECODE returns the stored value; no bypass is needed because WB precedes the next DECODE.
- instr_valid while not in IDLE: ignored; the instruction is not accepted, and the source must hold it.
- Reset mid-operation: immediate return to reset values; the in-flight instruction is discarded, with no done and no writeback.

Test Plan:
- Reset release, then ALU op opcode 3'b001, imm=1, imm 8'h05 (instr 16'h1805) -> done exactly 3 cycles after handshake; acc=8'h05; zero=0; instr_ready low for 3 cycles.
- acc=8'h05, then opcode 3'b101, imm 8'h07 (instr 16'h5807) -> acc=8'hFE (wrap); zero=0. Then opcode 3'b100, imm 8'h02 -> acc=8'h00; zero=1.
- acc=8'h3C, store to reg2 (instr 16'h8200), then XOR from reg2 (instr 16'h2200) -> reg2=8'h3C; acc=8'h00; zero=1; store does not change acc.
- acc=8'h81: opcode 3'b110 -> acc=8'h02; then opcode 3'b111 -> acc=8'h01; immediate field ignored.
- Hold instr_valid high continuously with back-to-back instructions -> exactly one accept per 4 cycles; none dropped or duplicated.
- Assert reset during EXEC of an ALU op loading 8'hAA -> acc=ACC_RESET; done never pulses; instr_ready=1 on the first cycle after reset deasserts.
